// File: rtl/ofdm_rx_byte_packer.sv
// Packs received QPSK dibits MSB-first into framed bytes and queues them in a
// first-word-fall-through FIFO; flags overflow and symbol-sync errors.
module ofdm_rx_byte_packer #(
  parameter int bits_per_carrier_c    = 2,
  parameter int carriers_per_symbol_c = 128,
  parameter int fifo_depth_c          = 16
) (
  input  logic                               sys_clk,
  input  logic                               sys_rstn,
  input  logic                               sys_init,
  input  logic [bits_per_carrier_c-1:0]      rx_rcv_data,
  input  logic                               rx_rcv_data_valid,
  input  logic                               rx_rcv_data_start,
  output logic [7:0]                         byte_data,
  output logic                               byte_valid,
  input  logic                               byte_ready,
  output logic                               byte_sof,
  output logic                               byte_eof,
  output logic                               overflow,
  output logic                               sync_err,
  output logic [15:0]                        symbol_count,
  output logic [$clog2(fifo_depth_c):0]      fifo_level,
  output logic [1:0]                         dbg_state
);

  localparam int cw_c = $clog2(carriers_per_symbol_c);
  localparam int aw_c = $clog2(fifo_depth_c);
  localparam logic [cw_c-1:0] last_carrier_c = cw_c'(carriers_per_symbol_c - 1);
  localparam logic [aw_c:0]   full_level_c   = (aw_c+1)'(fifo_depth_c);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  // Handshake: a byte moves when byte_valid && byte_ready at a rising edge;
  // the head (data/sof/eof) holds while byte_valid=1 and byte_ready=0.

  state_t            state_q, state_d;
  logic [cw_c-1:0]   carrier_q, carrier_d;
  logic [5:0]        shreg_q, shreg_d;
  logic              sync_err_q, sync_err_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       symbol_count_q, symbol_count_d;
  logic [aw_c:0]     wr_ptr_q, wr_ptr_d;
  logic [aw_c:0]     rd_ptr_q, rd_ptr_d;
  logic [9:0]        mem_q [fifo_depth_c];

  logic [aw_c:0]     level_w;
  logic              full_w;
  logic              push_w;
  logic              pop_w;
  logic [9:0]        push_word_w;
  logic [9:0]        head_w;

  assign level_w = wr_ptr_q - rd_ptr_q;
  assign full_w  = (level_w == full_level_c);
  assign pop_w   = byte_valid && byte_ready;
  // Word layout {sof, eof, byte}; the current beat supplies the low dibit.
  assign push_word_w = {(carrier_q[cw_c-1:2] == '0), (carrier_q == last_carrier_c),
                        shreg_q, rx_rcv_data};

  always_comb begin
    state_d        = state_q;
    carrier_d      = carrier_q;
    shreg_d        = shreg_q;
    sync_err_d     = 1'b0;
    overflow_d     = overflow_q;
    symbol_count_d = symbol_count_q;
    push_w         = 1'b0;
    if (rx_rcv_data_valid && rx_rcv_data_start) begin
      state_d    = ST_COLLECT;
      carrier_d  = cw_c'(1);
      shreg_d    = {4'b0000, rx_rcv_data};
      sync_err_d = (state_q == ST_COLLECT);
    end else if (rx_rcv_data_valid && state_q == ST_COLLECT) begin
      carrier_d = carrier_q + cw_c'(1);
      shreg_d   = {shreg_q[3:0], rx_rcv_data};
      if (carrier_q == last_carrier_c) state_d = ST_IDLE;
      if (carrier_q[1:0] == 2'b11) begin
        // Fullness uses the pre-edge level so a same-cycle pop cannot rescue the byte.
        if (!full_w) begin
          push_w = 1'b1;
          if (carrier_q == last_carrier_c) symbol_count_d = symbol_count_q + 16'd1;
        end else begin
          overflow_d = 1'b1;
          state_d    = ST_DISCARD;
        end
      end
    end
    wr_ptr_d = wr_ptr_q + (aw_c+1)'(push_w);
    rd_ptr_d = rd_ptr_q + (aw_c+1)'(pop_w);
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q        <= ST_IDLE;
      carrier_q      <= '0;
      shreg_q        <= '0;
      sync_err_q     <= 1'b0;
      overflow_q     <= 1'b0;
      symbol_count_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else if (sys_init) begin
      state_q        <= ST_IDLE;
      carrier_q      <= '0;
      shreg_q        <= '0;
      sync_err_q     <= 1'b0;
      overflow_q     <= 1'b0;
      symbol_count_q <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
    end else begin
      state_q        <= state_d;
      carrier_q      <= carrier_d;
      shreg_q        <= shreg_d;
      sync_err_q     <= sync_err_d;
      overflow_q     <= overflow_d;
      symbol_count_q <= symbol_count_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_w) mem_q[wr_ptr_q[aw_c-1:0]] <= push_word_w;
  end

  // Storage is never cleared, so the head is masked whenever the FIFO is empty.
  assign head_w       = mem_q[rd_ptr_q[aw_c-1:0]];
  assign byte_valid   = (level_w != '0);
  assign byte_data    = byte_valid ? head_w[7:0] : 8'h00;
  assign byte_eof     = byte_valid ? head_w[8] : 1'b0;
  assign byte_sof     = byte_valid ? head_w[9] : 1'b0;
  assign overflow     = overflow_q;
  assign sync_err     = sync_err_q;
  assign symbol_count = symbol_count_q;
  assign fifo_level   = level_w;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ofdm_rx_byte_packer.sv
// Directed bench for ofdm_rx_byte_packer: framing, overflow, sync errors,
// gapped input with back-pressure, async reset and synchronous init.
module tb_ofdm_rx_byte_packer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sys_init = 1'b0;
  logic [1:0] rx_data = 2'b00;
  logic       rx_valid = 1'b0;
  logic       rx_start = 1'b0;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic       byte_sof;
  logic       byte_eof;
  logic       overflow;
  logic       sync_err;
  logic [15:0] symbol_count;
  logic [4:0] fifo_level;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [1:0] pat [128];
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  logic       toggle_on = 1'b0;

  ofdm_rx_byte_packer dut (
    .sys_clk           (clk),
    .sys_rstn          (rst_n),
    .sys_init          (sys_init),
    .rx_rcv_data       (rx_data),
    .rx_rcv_data_valid (rx_valid),
    .rx_rcv_data_start (rx_start),
    .byte_data         (byte_data),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .byte_sof          (byte_sof),
    .byte_eof          (byte_eof),
    .overflow          (overflow),
    .sync_err          (sync_err),
    .symbol_count      (symbol_count),
    .fifo_level        (fifo_level),
    .dbg_state         (dbg_state)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after a rising edge, so the falling edge sees what the next edge will.
  always @(negedge clk) begin
    if (byte_valid && byte_ready) got_q.push_back({byte_sof, byte_eof, byte_data});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rx_valid = 1'b0; rx_start = 1'b0; sys_init = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic set_pattern(input int kind);
    for (int i = 0; i < 128; i++)
      pat[i] = (kind == 0) ? 2'(i % 4) : 2'((i * 3 + i / 5) % 4);
  endtask

  task automatic send_range(input int lo, input int hi, input bit start_lo, input int max_gap);
    for (int i = lo; i < hi; i++) begin
      rx_valid = 1'b1;
      rx_data  = pat[i];
      rx_start = start_lo && (i == lo);
      tick();
      rx_valid = 1'b0;
      rx_start = 1'b0;
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic expect_bytes(input int first, input int last, input bit with_eof);
    for (int b = first; b <= last; b++)
      exp_q.push_back({b == 0, with_eof && (b == 31),
                       pat[4*b], pat[4*b+1], pat[4*b+2], pat[4*b+3]});
  endtask

  task automatic wait_empty(input string tag);
    int k = 0;
    while (fifo_level != 0 && k < 300) begin tick(); k++; end
    check(tag, {27'd0, fifo_level}, 32'd0);
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_byte"}, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, byte_data}, 32'd0);
    check({tag, "_sof_eof"}, {30'd0, byte_sof, byte_eof}, 32'd0);
    check({tag, "_level"}, {27'd0, fifo_level}, 32'd0);
    check({tag, "_flags"}, {30'd0, overflow, sync_err}, 32'd0);
    check({tag, "_symcnt"}, {16'd0, symbol_count}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic mid_symbol_clear(input bit use_init);
    apply_reset();
    set_pattern(1);
    byte_ready = 1'b0;
    send_range(0, 22, 1'b1, 0);
    check("queued_level", {27'd0, fifo_level}, 32'd5);
    if (!use_init) begin
      rst_n = 1'b0;
      #1;
      check_cleared("async_rst");
      #2;
      rst_n = 1'b1;
      tick();
    end else begin
      sys_init = 1'b1;
      #1;
      check("init_not_yet", {27'd0, fifo_level}, 32'd5);
      tick();
      sys_init = 1'b0;
      check_cleared("sys_init");
    end
    got_q.delete();
    byte_ready = 1'b1;
    send_range(0, 128, 1'b1, 0);
    expect_bytes(0, 31, 1'b1);
    wait_empty("fresh_drain");
    tick();
    compare_bytes("fresh");
    check("fresh_symcnt", {16'd0, symbol_count}, 32'd1);
  endtask

  initial begin
    // Reset state and a single gapless symbol with latency checks on byte 0.
    apply_reset();
    check_cleared("reset");
    set_pattern(0);
    byte_ready = 1'b1;
    send_range(0, 4, 1'b1, 0);
    check("lat_valid", {31'd0, byte_valid}, 32'd1);
    check("lat_level", {27'd0, fifo_level}, 32'd1);
    check("lat_head", {22'd0, byte_sof, byte_eof, byte_data}, {22'd0, 2'b10, 8'h1B});
    send_range(4, 128, 1'b0, 0);
    expect_bytes(0, 31, 1'b1);
    wait_empty("t1_drain");
    tick();
    compare_bytes("t1");
    check("t1_symcnt", {16'd0, symbol_count}, 32'd1);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    check("t1_state", {30'd0, dbg_state}, 32'd0);

    // Overflow with byte_ready held low, head stability, then recovery.
    apply_reset();
    byte_ready = 1'b0;
    send_range(0, 4, 1'b1, 0);
    tick(); tick();
    check("hold_head", {22'd0, byte_sof, byte_eof, byte_data}, {22'd0, 2'b10, 8'h1B});
    send_range(4, 128, 1'b0, 0);
    check("ovf_level", {27'd0, fifo_level}, 32'd16);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_symcnt", {16'd0, symbol_count}, 32'd0);
    check("ovf_state", {30'd0, dbg_state}, 32'd2);
    byte_ready = 1'b1;
    expect_bytes(0, 15, 1'b0);
    wait_empty("ovf_drain");
    tick();
    compare_bytes("ovf");
    send_range(0, 128, 1'b1, 0);
    expect_bytes(0, 31, 1'b1);
    wait_empty("rec_drain");
    tick();
    compare_bytes("rec");
    check("rec_symcnt", {16'd0, symbol_count}, 32'd1);
    check("rec_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Restart at beat 10: two bytes survive, one sync_err pulse.
    apply_reset();
    set_pattern(1);
    byte_ready = 1'b1;
    send_range(0, 10, 1'b1, 0);
    check("pre_sync_err", {31'd0, sync_err}, 32'd0);
    send_range(0, 1, 1'b1, 0);
    check("sync_err_pulse", {31'd0, sync_err}, 32'd1);
    send_range(1, 2, 1'b0, 0);
    check("sync_err_drop", {31'd0, sync_err}, 32'd0);
    send_range(2, 128, 1'b0, 0);
    expect_bytes(0, 1, 1'b0);
    expect_bytes(0, 31, 1'b1);
    wait_empty("sync_drain");
    tick();
    compare_bytes("sync");
    check("sync_symcnt", {16'd0, symbol_count}, 32'd1);

    // Random gaps on input and random back-pressure on output.
    apply_reset();
    set_pattern(1);
    toggle_on = 1'b1;
    fork
      begin
        send_range(0, 128, 1'b1, 5);
        toggle_on = 1'b0;
      end
      begin
        while (toggle_on) begin
          byte_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    byte_ready = 1'b1;
    expect_bytes(0, 31, 1'b1);
    wait_empty("gap_drain");
    tick();
    compare_bytes("gap");
    check("gap_ovf", {31'd0, overflow}, 32'd0);
    check("gap_symcnt", {16'd0, symbol_count}, 32'd1);

    // Beats without a start are ignored, before and after a full symbol.
    apply_reset();
    set_pattern(0);
    send_range(4, 24, 1'b0, 0);
    check("nostart_level", {27'd0, fifo_level}, 32'd0);
    check("nostart_state", {30'd0, dbg_state}, 32'd0);
    send_range(0, 128, 1'b1, 0);
    send_range(0, 5, 1'b0, 0);
    check("after_state", {30'd0, dbg_state}, 32'd0);
    expect_bytes(0, 31, 1'b1);
    wait_empty("after_drain");
    repeat (3) tick();
    compare_bytes("after");
    check("after_level", {27'd0, fifo_level}, 32'd0);

    mid_symbol_clear(1'b0);
    mid_symbol_clear(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
